button_bounce_gen: RTL and testbench

BUTTON_BOUNCE_GEN -- requirements
Module: button_bounce_gen

---
 rtl/button_bounce_gen.sv | 199 +++++++++++++++++++
 tb/tb_button_bounce_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/button_bounce_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : button_bounce_gen                                          |
// | Description : Emulates one bouncy press/release of an active-low push    |
// |               button per press_req. The sequence has four phases:        |
// |               press bounce, stable hold (low) and release bounce, then   |
// |               a return to idle (high). Bounce values come from an 8-bit  |
// |               Fibonacci LFSR, and runs of lows are capped.               |
// | Ports       : clk          - single clock, rising edge                   |
// |               reset        - synchronous, active-high                    |
// |               press_req    - start one sequence (ignored while busy)     |
// |               noisy_button - registered emulated button (1 = released)   |
// |               busy         - high while a sequence is in progress        |
// |               done         - one-cycle pulse on the first idle cycle     |
// |               press_count  - completed-sequence counter (optional)       |
// | Option      : define BUTTON_BOUNCE_GEN_PRESS_COUNT_EN to add the         |
// |               press_count output and its counter.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module button_bounce_gen #(
  parameter int unsigned BOUNCE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 10,
  parameter int unsigned MAX_GLITCH    = 3,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        press_req,
  output logic        noisy_button,
  output logic        busy,
  output logic        done
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
  ,
  output logic [15:0] press_count
`endif
);

  // An all-zero seed would lock the LFSR, so it is replaced.
  localparam logic [7:0]  c_seed        = (LFSR_SEED == 8'h00) ? 8'hA5 : LFSR_SEED;
  // Duration counters are loaded with N-1 and run down to 0 (N cycles).
  localparam logic [15:0] c_bounce_load = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] c_hold_load   = 16'(HOLD_CYCLES - 1);
  localparam logic [7:0]  c_max_glitch  = 8'(MAX_GLITCH);

  typedef enum logic [1:0] {
    S_IDLE           = 2'd0,
    S_PRESS_BOUNCE   = 2'd1,
    S_HOLD           = 2'd2,
    S_RELEASE_BOUNCE = 2'd3
  } state_t;

  state_t      state_q,  state_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [7:0]  lfsr_q,   lfsr_d;
  logic [7:0]  glitch_q, glitch_d;
  logic        noisy_q,  noisy_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  logic        bounce_step;   // this edge produces a bounce cycle
  logic [7:0]  glitch_base;   // low-run count seen by this bounce cycle
  logic [7:0]  lfsr_next;

`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
  logic [15:0] press_count_q, press_count_d;
`endif

  // x^8+x^6+x^5+x^4+1: taps on bits 7,5,4,3, feedback shifted into bit 0.
  always_comb begin
    lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    glitch_d    = glitch_q;
    noisy_d     = noisy_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bounce_step = 1'b0;
    glitch_base = glitch_q;

    case (state_q)
      S_IDLE: begin
        noisy_d = 1'b1;
        busy_d  = 1'b0;
        if (press_req) begin
          state_d     = S_PRESS_BOUNCE;
          cnt_d       = c_bounce_load;
          busy_d      = 1'b1;
          bounce_step = 1'b1;
          glitch_base = 8'd0;
        end
      end

      S_PRESS_BOUNCE: begin
        if (cnt_q == 16'd0) begin
          state_d  = S_HOLD;
          cnt_d    = c_hold_load;
          noisy_d  = 1'b0;
          glitch_d = 8'd0;
        end else begin
          cnt_d       = cnt_q - 16'd1;
          bounce_step = 1'b1;
        end
      end

      S_HOLD: begin
        noisy_d = 1'b0;
        if (cnt_q == 16'd0) begin
          state_d     = S_RELEASE_BOUNCE;
          cnt_d       = c_bounce_load;
          bounce_step = 1'b1;
          glitch_base = 8'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_RELEASE_BOUNCE: begin
        if (cnt_q == 16'd0) begin
          state_d  = S_IDLE;
          noisy_d  = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          glitch_d = 8'd0;
        end else begin
          cnt_d       = cnt_q - 16'd1;
          bounce_step = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        noisy_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // The LFSR always advances on a bounce cycle. Only the output bit is
    // forced high when the low run has already reached the cap.
    if (bounce_step) begin
      lfsr_d = lfsr_next;
      if (lfsr_next[0]) begin
        noisy_d  = 1'b1;
        glitch_d = 8'd0;
      end else if (glitch_base == c_max_glitch) begin
        noisy_d  = 1'b1;
        glitch_d = 8'd0;
      end else begin
        noisy_d  = 1'b0;
        glitch_d = glitch_base + 8'd1;
      end
    end
  end

`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
  // The count steps on the same edge that raises done and wraps naturally.
  always_comb begin
    press_count_d = press_count_q + {15'd0, done_d};
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      lfsr_q        <= c_seed;
      glitch_q      <= 8'd0;
      noisy_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
      press_count_q <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      glitch_q      <= glitch_d;
      noisy_q       <= noisy_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
      press_count_q <= press_count_d;
`endif
    end
  end

  assign noisy_button = noisy_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
  assign press_count  = press_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_bounce_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_button_bounce_gen                                       |
// | Description : Scoreboard bench for button_bounce_gen. Three instances    |
// |               share one stimulus: default (a), MAX_GLITCH=1 (b) and     |
// |               LFSR_SEED=0 (c, same trace as a). The expected per-cycle  |
// |               traces were derived by hand from the LFSR sequence for     |
// |               seed 8'hA5.                                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_button_bounce_gen;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic press_req = 1'b0;

  logic noisy_a, busy_a, done_a;
  logic noisy_b, busy_b, done_b;
  logic noisy_c, busy_c, done_c;
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
  logic [15:0] pc_a, pc_b, pc_c;
`endif

  always #5 clk = ~clk;

  button_bounce_gen u_dut_a (
    .clk(clk), .reset(reset), .press_req(press_req),
    .noisy_button(noisy_a), .busy(busy_a), .done(done_a)
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
    , .press_count(pc_a)
`endif
  );

  button_bounce_gen #(.MAX_GLITCH(1)) u_dut_b (
    .clk(clk), .reset(reset), .press_req(press_req),
    .noisy_button(noisy_b), .busy(busy_b), .done(done_b)
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
    , .press_count(pc_b)
`endif
  );

  button_bounce_gen #(.LFSR_SEED(8'h00)) u_dut_c (
    .clk(clk), .reset(reset), .press_req(press_req),
    .noisy_button(noisy_c), .busy(busy_c), .done(done_c)
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
    , .press_count(pc_c)
`endif
  );

  // Traces for cycles 1..26 of a sequence (bit k = cycle k+1).
  // First sequence after reset, MAX_GLITCH=3:
  //   press 0 1 0 0 1 1 1 0 | hold 0 x10 | release 1 1 1 0 1 1 0 0
  // Same with MAX_GLITCH=1 (press cycle 4, release cycle 8 forced high):
  //   press 0 1 0 1 1 1 1 0 | hold 0 x10 | release 1 1 1 0 1 1 0 1
  // Second sequence after reset (continued LFSR):
  //   a: press 1 1 1 1 0 1 1 1 | release 1 1 1 0 1 0 0 1
  //   b: press 1 1 1 1 0 1 1 1 | release 1 1 1 0 1 0 1 1
  logic [25:0] pat_a1 = 26'b00110111_0000000000_01110010;
  logic [25:0] pat_b1 = 26'b10110111_0000000000_01111010;
  logic [25:0] pat_a2 = 26'b10010111_0000000000_11101111;
  logic [25:0] pat_b2 = 26'b11010111_0000000000_11101111;

  typedef struct packed {
    logic busy;
    logic na;
    logic nb;
    logic done;
  } exp_t;

  exp_t sb_q[$];
  int   tag_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input int tag,
                       input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, tag, act, req);
  endtask

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic step(input logic p, input logic r, input logic eb,
                      input logic ea, input logic ebn, input logic ed);
    exp_t e;
    @(negedge clk);
    #1;
    press_req = p;
    reset     = r;
    e.busy = eb; e.na = ea; e.nb = ebn; e.done = ed;
    sb_q.push_back(e);
    tag_q.push_back(cyc);
    cyc++;
  endtask

  task automatic idle(input logic p, input logic r);
    step(p, r, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // pv[k] is press_req at the edge that starts sequence cycle k+1;
  // pv[26] is sampled at the edge that produces the done cycle.
  task automatic run_seq(input logic [25:0] ea, input logic [25:0] eb,
                         input logic [26:0] pv);
    for (int k = 0; k < 26; k++)
      step(pv[k], 1'b0, 1'b1, ea[k], eb[k], 1'b0);
    step(pv[26], 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    int   t;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check("busy",    t, {15'd0, busy_a},  {15'd0, e.busy});
        check("done",    t, {15'd0, done_a},  {15'd0, e.done});
        check("noisy_a", t, {15'd0, noisy_a}, {15'd0, e.na});
        check("noisy_b", t, {15'd0, noisy_b}, {15'd0, e.nb});
        check("noisy_c_seed0", t, {15'd0, noisy_c}, {15'd0, e.na});
        check("busy_done_bc", t, {12'd0, busy_b, busy_c, done_b, done_c},
              {12'd0, e.busy, e.busy, e.done, e.done});
      end
    end
  end

  initial begin
    // Reset wins over a simultaneous press_req.
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);

    // Single press, with extra pulses in cycles 5, 12 and 26 that must be ignored.
    run_seq(pat_a1, pat_b1, 27'h4001021);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);

    // Reset, then press held for 30 cycles: a second sequence starts in the done cycle.
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    run_seq(pat_a1, pat_b1, 27'h7FFFFFF);
    run_seq(pat_a2, pat_b2, 27'h0000007);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
    @(negedge clk);
    #2;
    check("press_count_two", cyc, pc_a, 16'd2);
`endif

    // Reset during HOLD cycle 3 for two edges: no done, then a seed-identical run.
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
`ifdef BUTTON_BOUNCE_GEN_PRESS_COUNT_EN
    @(negedge clk);
    #2;
    check("press_count_reset", cyc, pc_a, 16'd0);
`endif
    for (int k = 0; k < 11; k++)
      step((k == 0), 1'b0, 1'b1, pat_a1[k], pat_b1[k], 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0);
    run_seq(pat_a1, pat_b1, 27'h0000001);
    for (int i = 0; i < 2; i++) idle(1'b0, 1'b0);

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #2;
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
